// File: rtl/fp_rename_table.sv
// FP register rename table: NUM_CHECKPOINTS speculative maps plus a committed map.
// Optional per-entry ready bits are enabled by defining FP_RENAME_READY_BITS_EN.
module fp_rename_table #(
  parameter int unsigned NUM_ISA_REGISTERS       = 32,
  parameter int unsigned NUM_PHYSICAL_FREGISTERS = 64,
  parameter int unsigned NUM_CHECKPOINTS         = 4
) (
  input  logic                                       clk_i,
  input  logic                                       rstn_i,
  input  logic [$clog2(NUM_ISA_REGISTERS)-1:0]       src1_i,
  input  logic [$clog2(NUM_ISA_REGISTERS)-1:0]       src2_i,
  input  logic [$clog2(NUM_ISA_REGISTERS)-1:0]       src3_i,
  input  logic                                       write_dst_i,
  input  logic [$clog2(NUM_ISA_REGISTERS)-1:0]       old_dst_i,
  input  logic [$clog2(NUM_PHYSICAL_FREGISTERS)-1:0] new_dst_i,
  input  logic                                       ready_i,
  input  logic [$clog2(NUM_PHYSICAL_FREGISTERS)-1:0] vaddr_i,
  input  logic                                       commit_write_i,
  input  logic [$clog2(NUM_ISA_REGISTERS)-1:0]       commit_dst_i,
  input  logic [$clog2(NUM_PHYSICAL_FREGISTERS)-1:0] commit_preg_i,
  input  logic                                       do_checkpoint_i,
  input  logic                                       do_recover_i,
  input  logic                                       delete_checkpoint_i,
  input  logic [$clog2(NUM_CHECKPOINTS)-1:0]         recover_checkpoint_i,
  input  logic                                       commit_roll_back_i,
  output logic [$clog2(NUM_PHYSICAL_FREGISTERS)-1:0] src1_o,
  output logic                                       rdy1_o,
  output logic [$clog2(NUM_PHYSICAL_FREGISTERS)-1:0] src2_o,
  output logic                                       rdy2_o,
  output logic [$clog2(NUM_PHYSICAL_FREGISTERS)-1:0] src3_o,
  output logic                                       rdy3_o,
  output logic [$clog2(NUM_PHYSICAL_FREGISTERS)-1:0] old_dst_o,
  output logic [$clog2(NUM_CHECKPOINTS)-1:0]         checkpoint_o,
  output logic                                       out_of_checkpoints_o
);

  localparam int unsigned PW = $clog2(NUM_PHYSICAL_FREGISTERS);
  localparam int unsigned CW = $clog2(NUM_CHECKPOINTS);
  localparam int unsigned AW = $clog2(NUM_ISA_REGISTERS);

  typedef logic [PW-1:0] phfreg_t;
  typedef logic [CW-1:0] checkpoint_ptr_t;
  typedef logic [AW-1:0] areg_t;

  phfreg_t         map_q  [NUM_CHECKPOINTS][NUM_ISA_REGISTERS];
  phfreg_t         map_d  [NUM_CHECKPOINTS][NUM_ISA_REGISTERS];
  phfreg_t         cmap_q [NUM_ISA_REGISTERS];
  phfreg_t         cmap_d [NUM_ISA_REGISTERS];
`ifdef FP_RENAME_READY_BITS_EN
  logic            rdy_q  [NUM_CHECKPOINTS][NUM_ISA_REGISTERS];
  logic            rdy_d  [NUM_CHECKPOINTS][NUM_ISA_REGISTERS];
`endif
  checkpoint_ptr_t head_q, head_d;
  checkpoint_ptr_t tail_q, tail_d;
  checkpoint_ptr_t num_q,  num_d;
  checkpoint_ptr_t ckpt_q;
  checkpoint_ptr_t head_nxt;
  logic            rename_en;
  logic            checkpoint_en;

  assign rename_en     = write_dst_i & ~do_recover_i & ~commit_roll_back_i;
  assign checkpoint_en = do_checkpoint_i & (num_q < checkpoint_ptr_t'(NUM_CHECKPOINTS - 1))
                         & ~do_recover_i & ~commit_roll_back_i;
  assign head_nxt      = head_q + checkpoint_ptr_t'(1);

  // Update order matters: writeback, then rename, then checkpoint copy of the
  // updated active map, and rollback overwrites map 0 last.
  always_comb begin
    map_d  = map_q;
    cmap_d = cmap_q;
`ifdef FP_RENAME_READY_BITS_EN
    rdy_d  = rdy_q;
`endif
    if (commit_write_i) cmap_d[commit_dst_i] = commit_preg_i;

`ifdef FP_RENAME_READY_BITS_EN
    if (ready_i) begin
      for (int unsigned c = 0; c < NUM_CHECKPOINTS; c++) begin
        for (int unsigned e = 0; e < NUM_ISA_REGISTERS; e++) begin
          if (map_q[checkpoint_ptr_t'(c)][areg_t'(e)] == vaddr_i)
            rdy_d[checkpoint_ptr_t'(c)][areg_t'(e)] = 1'b1;
        end
      end
    end
`endif

    if (rename_en) begin
      map_d[head_q][old_dst_i] = new_dst_i;
`ifdef FP_RENAME_READY_BITS_EN
      rdy_d[head_q][old_dst_i] = ready_i & (new_dst_i == vaddr_i);
`endif
    end

    if (checkpoint_en) begin
      for (int unsigned e = 0; e < NUM_ISA_REGISTERS; e++) begin
        map_d[head_nxt][areg_t'(e)] = map_d[head_q][areg_t'(e)];
`ifdef FP_RENAME_READY_BITS_EN
        rdy_d[head_nxt][areg_t'(e)] = rdy_d[head_q][areg_t'(e)];
`endif
      end
    end

    if (commit_roll_back_i) begin
      for (int unsigned e = 0; e < NUM_ISA_REGISTERS; e++) begin
        map_d[0][areg_t'(e)] = cmap_d[areg_t'(e)];
`ifdef FP_RENAME_READY_BITS_EN
        rdy_d[0][areg_t'(e)] = 1'b1;
`endif
      end
    end
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    num_d  = num_q;
    if (commit_roll_back_i) begin
      head_d = '0;
      tail_d = '0;
      num_d  = '0;
    end else begin
      tail_d = tail_q + checkpoint_ptr_t'(delete_checkpoint_i);
      if (do_recover_i) begin
        head_d = recover_checkpoint_i;
        num_d  = recover_checkpoint_i - tail_q;
      end else begin
        head_d = head_q + checkpoint_ptr_t'(checkpoint_en);
        num_d  = num_q + checkpoint_ptr_t'(checkpoint_en)
                       - checkpoint_ptr_t'(delete_checkpoint_i);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      for (int unsigned c = 0; c < NUM_CHECKPOINTS; c++) begin
        for (int unsigned e = 0; e < NUM_ISA_REGISTERS; e++) begin
          map_q[checkpoint_ptr_t'(c)][areg_t'(e)] <= phfreg_t'(e);
`ifdef FP_RENAME_READY_BITS_EN
          rdy_q[checkpoint_ptr_t'(c)][areg_t'(e)] <= 1'b1;
`endif
        end
      end
      for (int unsigned e = 0; e < NUM_ISA_REGISTERS; e++) begin
        cmap_q[areg_t'(e)] <= phfreg_t'(e);
      end
      head_q <= '0;
      tail_q <= '0;
      num_q  <= '0;
      ckpt_q <= '0;
    end else begin
      map_q  <= map_d;
      cmap_q <= cmap_d;
`ifdef FP_RENAME_READY_BITS_EN
      rdy_q  <= rdy_d;
`endif
      head_q <= head_d;
      tail_q <= tail_d;
      num_q  <= num_d;
      ckpt_q <= head_d;
    end
  end

  assign src1_o    = map_q[head_q][src1_i];
  assign src2_o    = map_q[head_q][src2_i];
  assign src3_o    = map_q[head_q][src3_i];
  assign old_dst_o = map_q[head_q][old_dst_i];

`ifdef FP_RENAME_READY_BITS_EN
  assign rdy1_o = rdy_q[head_q][src1_i];
  assign rdy2_o = rdy_q[head_q][src2_i];
  assign rdy3_o = rdy_q[head_q][src3_i];
`else
  logic unused_wb;
  assign unused_wb = ready_i ^ (^vaddr_i);
  assign rdy1_o = 1'b1;
  assign rdy2_o = 1'b1;
  assign rdy3_o = 1'b1;
`endif

  assign checkpoint_o         = ckpt_q;
  assign out_of_checkpoints_o = (num_q == checkpoint_ptr_t'(NUM_CHECKPOINTS - 1));

endmodule

// File: tb/tb_fp_rename_table.sv
// Self-checking bench for fp_rename_table: directed scenarios then a random
// rename/writeback phase against a model of the active map.
module tb_fp_rename_table;

`ifdef FP_RENAME_READY_BITS_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic [4:0] src1, src2, src3, old_dst, commit_dst;
  logic [5:0] new_dst, vaddr, commit_preg;
  logic       write_dst, ready, commit_write, do_ckpt, do_rec, del_ckpt, roll_back;
  logic [1:0] rec_ckpt;
  logic [5:0] src1_o, src2_o, src3_o, old_dst_o;
  logic       rdy1_o, rdy2_o, rdy3_o, ooc_o;
  logic [1:0] ckpt_o;

  always #5 clk = ~clk;

  fp_rename_table #(
    .NUM_ISA_REGISTERS      (32),
    .NUM_PHYSICAL_FREGISTERS(64),
    .NUM_CHECKPOINTS        (4)
  ) dut (
    .clk_i               (clk),
    .rstn_i              (rstn),
    .src1_i              (src1),
    .src2_i              (src2),
    .src3_i              (src3),
    .write_dst_i         (write_dst),
    .old_dst_i           (old_dst),
    .new_dst_i           (new_dst),
    .ready_i             (ready),
    .vaddr_i             (vaddr),
    .commit_write_i      (commit_write),
    .commit_dst_i        (commit_dst),
    .commit_preg_i       (commit_preg),
    .do_checkpoint_i     (do_ckpt),
    .do_recover_i        (do_rec),
    .delete_checkpoint_i (del_ckpt),
    .recover_checkpoint_i(rec_ckpt),
    .commit_roll_back_i  (roll_back),
    .src1_o              (src1_o),
    .rdy1_o              (rdy1_o),
    .src2_o              (src2_o),
    .rdy2_o              (rdy2_o),
    .src3_o              (src3_o),
    .rdy3_o              (rdy3_o),
    .old_dst_o           (old_dst_o),
    .checkpoint_o        (ckpt_o),
    .out_of_checkpoints_o(ooc_o)
  );

  typedef enum int {K_SRC1, K_SRC2, K_SRC3, K_RDY1, K_RDY2, K_RDY3, K_OLD, K_CKPT, K_OOC} kind_e;
  typedef struct {
    kind_e k;
    int    v;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   mdl  [32];
  bit   mrdy [32];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic want(input kind_e k, input int v);
    sbq.push_back('{k, v});
  endtask

  function automatic int rexp(input bit b);
    return RB ? int'(b) : 1;
  endfunction

  task automatic drain();
    exp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      case (e.k)
        K_SRC1: check_eq("src1", 32'(src1_o), e.v);
        K_SRC2: check_eq("src2", 32'(src2_o), e.v);
        K_SRC3: check_eq("src3", 32'(src3_o), e.v);
        K_RDY1: check_eq("rdy1", 32'(rdy1_o), e.v);
        K_RDY2: check_eq("rdy2", 32'(rdy2_o), e.v);
        K_RDY3: check_eq("rdy3", 32'(rdy3_o), e.v);
        K_OLD:  check_eq("old_dst", 32'(old_dst_o), e.v);
        K_CKPT: check_eq("checkpoint", 32'(ckpt_o), e.v);
        default: check_eq("out_of_ckpt", 32'(ooc_o), e.v);
      endcase
    end
  endtask

  task automatic idle();
    src1 = '0; src2 = '0; src3 = '0; old_dst = '0; new_dst = '0;
    write_dst = 1'b0; ready = 1'b0; vaddr = '0;
    commit_write = 1'b0; commit_dst = '0; commit_preg = '0;
    do_ckpt = 1'b0; do_rec = 1'b0; del_ckpt = 1'b0; rec_ckpt = '0; roll_back = 1'b0;
  endtask

  // Inputs are set just after a rising edge; outputs compared at the falling edge.
  task automatic cycle();
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    idle();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    // Reset state
    src1 = 5; src2 = 0; src3 = 31; old_dst = 9;
    want(K_SRC1, 5); want(K_SRC2, 0); want(K_SRC3, 31);
    want(K_RDY1, 1); want(K_RDY2, 1); want(K_RDY3, 1);
    want(K_OLD, 9); want(K_CKPT, 0); want(K_OOC, 0);
    cycle();

    // Own destination is not visible in the rename cycle
    write_dst = 1; old_dst = 1; new_dst = 42; src1 = 1;
    want(K_OLD, 1); want(K_SRC1, 1); want(K_RDY1, 1);
    cycle();

    src1 = 1; write_dst = 1; old_dst = 3; new_dst = 40;
    want(K_SRC1, 42); want(K_RDY1, rexp(0)); want(K_OLD, 3);
    cycle();

    src2 = 3; src1 = 1; ready = 1; vaddr = 40;
    want(K_SRC2, 40); want(K_RDY2, rexp(0)); want(K_RDY1, rexp(0));
    cycle();

    src2 = 3; src1 = 1;
    want(K_SRC2, 40); want(K_RDY2, 1); want(K_RDY1, rexp(0));
    cycle();

    // Checkpoint/recover
    write_dst = 1; old_dst = 3; new_dst = 40; do_ckpt = 1;
    want(K_OLD, 40); want(K_CKPT, 0);
    cycle();

    do_ckpt = 1; src1 = 3;
    want(K_CKPT, 1); want(K_SRC1, 40); want(K_OOC, 0);
    cycle();

    write_dst = 1; old_dst = 3; new_dst = 41;
    want(K_CKPT, 2); want(K_OLD, 40);
    cycle();

    src1 = 3; do_rec = 1; rec_ckpt = 1;
    want(K_SRC1, 41);
    cycle();

    src1 = 3; do_ckpt = 1;
    want(K_SRC1, 40); want(K_CKPT, 1); want(K_OOC, 0); want(K_RDY1, rexp(0));
    cycle();

    do_ckpt = 1;
    want(K_CKPT, 2); want(K_OOC, 0);
    cycle();

    // Full: a further checkpoint request is ignored
    do_ckpt = 1;
    want(K_CKPT, 3); want(K_OOC, 1);
    cycle();

    del_ckpt = 1;
    want(K_CKPT, 3); want(K_OOC, 1);
    cycle();

    do_ckpt = 1; del_ckpt = 1;
    want(K_CKPT, 3); want(K_OOC, 0);
    cycle();

    src1 = 3; do_ckpt = 1;
    want(K_CKPT, 0); want(K_OOC, 0); want(K_SRC1, 40);
    cycle();

    do_rec = 1; rec_ckpt = 3;
    want(K_OOC, 1); want(K_CKPT, 1);
    cycle();

    // Commit and rollback
    commit_write = 1; commit_dst = 7; commit_preg = 50;
    write_dst = 1; old_dst = 7; new_dst = 51; src1 = 3;
    want(K_CKPT, 3); want(K_OOC, 0); want(K_OLD, 7); want(K_SRC1, 40);
    cycle();

    src1 = 7; roll_back = 1; commit_write = 1; commit_dst = 8; commit_preg = 60;
    write_dst = 1; old_dst = 7; new_dst = 52; do_ckpt = 1; do_rec = 1; rec_ckpt = 2;
    want(K_SRC1, 51);
    cycle();

    src1 = 7; src2 = 8; src3 = 3;
    want(K_SRC1, 50); want(K_SRC2, 60); want(K_SRC3, 3);
    want(K_CKPT, 0); want(K_OOC, 0); want(K_RDY1, 1);
    cycle();

    // Reset mid-operation
    rstn = 1'b0; write_dst = 1; old_dst = 5; new_dst = 55; do_ckpt = 1;
    cycle();
    rstn = 1'b1;
    src1 = 5; src2 = 7; src3 = 8; roll_back = 1;
    want(K_SRC1, 5); want(K_SRC2, 7); want(K_SRC3, 8); want(K_CKPT, 0); want(K_OOC, 0);
    cycle();

    src1 = 7; src2 = 8;
    want(K_SRC1, 7); want(K_SRC2, 8); want(K_CKPT, 0);
    cycle();

    // Random renames and writebacks on the active map
    for (int i = 0; i < 32; i++) begin
      mdl[i]  = i;
      mrdy[i] = 1'b1;
    end
    for (int n = 0; n < 60; n++) begin
      src1 = 5'($urandom_range(0, 31));
      src2 = 5'($urandom_range(0, 31));
      src3 = 5'($urandom_range(0, 31));
      old_dst   = 5'($urandom_range(0, 31));
      new_dst   = 6'($urandom_range(32, 63));
      write_dst = 1'($urandom_range(0, 1));
      ready     = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       vaddr = new_dst;
        1:       vaddr = 6'(mdl[$urandom_range(0, 31)]);
        default: vaddr = 6'($urandom_range(0, 63));
      endcase
      want(K_SRC1, mdl[src1]); want(K_RDY1, rexp(mrdy[src1]));
      want(K_SRC2, mdl[src2]); want(K_RDY2, rexp(mrdy[src2]));
      want(K_SRC3, mdl[src3]); want(K_RDY3, rexp(mrdy[src3]));
      want(K_OLD, mdl[old_dst]);
      if (ready) begin
        for (int e = 0; e < 32; e++) if (mdl[e] == int'(vaddr)) mrdy[e] = 1'b1;
      end
      if (write_dst) begin
        mdl[old_dst]  = int'(new_dst);
        mrdy[old_dst] = ready && (new_dst == vaddr);
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
